// File: rtl/m_serial_alu_pkg.sv
// Shared definitions for the digit-serial ALU: op codes, FSM states and
// elaboration-time helpers for parameter checking and op classification.
package m_serial_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // DIGIT must be a supported power of two and split WIDTH into at least two digits.
    function automatic logic digit_legal(input int unsigned width, input int unsigned digit);
        return ((digit == 1) || (digit == 2) || (digit == 4) || (digit == 8)) &&
               ((width % digit) == 0) && ((width / digit) >= 2);
    endfunction

    function automatic logic op_inverts_b(input logic [3:0] sel);
        return (sel == ALU_SUB) || (sel == ALU_SLT) || (sel == ALU_SLTU);
    endfunction

endpackage

// File: rtl/m_serial_alu_digit_adder.sv
// DIGIT-wide ripple-carry adder slice; also exposes the carry into its top bit
// so the caller can derive signed overflow on the final digit.
module m_digit_adder #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/m_serial_alu.sv
// Digit-serial ALU: operands are consumed LSB-first DIGIT bits per cycle with a
// registered carry; results and flags are published with a one-cycle valid pulse.
module m_serial_alu
    import m_serial_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 1
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic             w_start,
    input  logic [3:0]       w_sel,
    input  logic [WIDTH-1:0] w_rrs,
    input  logic [WIDTH-1:0] w_rrt,
    output logic             w_busy,
    output logic             w_valid,
    output logic [WIDTH-1:0] w_rslt,
    output logic             w_cout,
    output logic             w_ovf
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    generate
        if (!digit_legal(WIDTH, DIGIT)) begin : g_bad_digit
            $error("m_serial_alu: DIGIT must be 1, 2, 4 or 8 and divide WIDTH into >= 2 digits");
        end
    endgenerate

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [3:0]       sel_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             valid_q;
    logic [WIDTH-1:0] rslt_q;
    logic [WIDTH-1:0] rslt_d;
    logic             cout_q;
    logic             cout_d;
    logic             ovf_q;
    logic             ovf_d;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_raw;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] sum_dig;
    logic [DIGIT-1:0] dig_res;
    logic             add_cout;
    logic             add_c_msb;

    assign a_dig = a_q[DIGIT-1:0];
    assign b_raw = b_q[DIGIT-1:0];
    assign b_dig = op_inverts_b(sel_q) ? ~b_raw : b_raw;

    m_digit_adder #(
        .DIGIT(DIGIT)
    ) u_digit_adder (
        .a        (a_dig),
        .b        (b_dig),
        .cin      (carry_q),
        .sum      (sum_dig),
        .cout     (add_cout),
        .c_msb_in (add_c_msb)
    );

    always_comb begin
        dig_res = '0;
        case (sel_q)
            ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU: dig_res = sum_dig;
            ALU_AND:                             dig_res = a_dig & b_raw;
            ALU_OR:                              dig_res = a_dig | b_raw;
            ALU_XOR:                             dig_res = a_dig ^ b_raw;
            ALU_NOR:                             dig_res = ~(a_dig | b_raw);
            default:                             dig_res = '0;
        endcase
    end

    // Result digits enter at the MSB end so the last digit lands the word in place.
    assign res_d = {dig_res, res_q[WIDTH-1:DIGIT]};

    // Only meaningful on the final digit, when the adder sees the operands' top bits.
    always_comb begin
        rslt_d = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        case (sel_q)
            ALU_ADD, ALU_SUB: begin
                rslt_d = res_d;
                cout_d = add_cout;
                ovf_d  = add_c_msb ^ add_cout;
            end
            ALU_AND, ALU_OR, ALU_XOR, ALU_NOR: begin
                rslt_d = res_d;
            end
            ALU_SLT: begin
                rslt_d[0] = res_d[WIDTH-1] ^ add_c_msb ^ add_cout;
                cout_d    = add_cout;
            end
            ALU_SLTU: begin
                rslt_d[0] = ~add_cout;
                cout_d    = add_cout;
            end
            default: begin
                rslt_d = '0;
            end
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sel_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            rslt_q  <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    if (w_start) begin
                        a_q     <= w_rrs;
                        b_q     <= w_rrt;
                        sel_q   <= w_sel;
                        carry_q <= op_inverts_b(w_sel);
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    res_q   <= res_d;
                    carry_q <= add_cout;
                    if (cnt_q == CNT_LAST) begin
                        rslt_q  <= rslt_d;
                        cout_q  <= cout_d;
                        ovf_q   <= ovf_d;
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign w_busy  = busy_q;
    assign w_valid = valid_q;
    assign w_rslt  = rslt_q;
    assign w_cout  = cout_q;
    assign w_ovf   = ovf_q;

endmodule
